// File: rtl/median_window_3x3.sv
// 3x3 median filter stage fed by a two-line shift RAM: builds the window, sorts it
// through a three-stage comparator network and re-emits syncs with a matching 4-clock delay.
module median_window_3x3 #(
  parameter int DATA_W = 8,
  parameter int COL_W  = 11,
  parameter int LINE_W = 11
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] row_top,
  input  logic [DATA_W-1:0] row_mid,
  input  logic [DATA_W-1:0] row_bot,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_y
);

  typedef logic [DATA_W-1:0] pix_t;

  localparam logic [COL_W-1:0]  COL_MAX  = '1;
  localparam logic [LINE_W-1:0] LINE_MAX = '1;

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a >= b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a >= b) ? b : a;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // sync vectors are {vsync, href, clken}; bit 0 doubles as the data valid
  logic [COL_W-1:0]  col_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              href_d;
  logic              vsync_d;

  pix_t       win [3][3];
  logic [2:0] s0_sync;
  logic       s0_border;

  pix_t       s1_max [3];
  pix_t       s1_mid [3];
  pix_t       s1_min [3];
  pix_t       s1_center;
  logic [2:0] s1_sync;
  logic       s1_border;

  pix_t       s2_max_of_mins;
  pix_t       s2_mid_of_mids;
  pix_t       s2_min_of_maxes;
  pix_t       s2_center;
  logic [2:0] s2_sync;
  logic       s2_border;

  // Position counters; a vsync rise wins over a coincident href fall.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= '0;
      line_cnt <= '0;
      href_d   <= 1'b0;
      vsync_d  <= 1'b0;
    end else begin
      href_d  <= per_frame_href;
      vsync_d <= per_frame_vsync;
      if (!per_frame_href) begin
        col_cnt <= '0;
      end else if (per_frame_clken && col_cnt != COL_MAX) begin
        col_cnt <= col_cnt + COL_W'(1);
      end
      if (per_frame_vsync && !vsync_d) begin
        line_cnt <= '0;
      end else if (href_d && !per_frame_href && line_cnt != LINE_MAX) begin
        line_cnt <= line_cnt + LINE_W'(1);
      end
    end
  end

  // S0: column shift registers, index 0 is the newest column
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
      s0_sync   <= '0;
      s0_border <= 1'b0;
    end else begin
      if (per_frame_clken) begin
        for (int r = 0; r < 3; r++) begin
          win[r][2] <= win[r][1];
          win[r][1] <= win[r][0];
        end
        win[0][0] <= row_top;
        win[1][0] <= row_mid;
        win[2][0] <= row_bot;
      end
      s0_sync   <= {per_frame_vsync, per_frame_href, per_frame_clken};
      s0_border <= (col_cnt < COL_W'(2)) || (line_cnt < LINE_W'(2));
    end
  end

  // S1: per-row sort
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        s1_max[r] <= '0;
        s1_mid[r] <= '0;
        s1_min[r] <= '0;
      end
      s1_center <= '0;
      s1_sync   <= '0;
      s1_border <= 1'b0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        s1_max[r] <= max3(win[r][0], win[r][1], win[r][2]);
        s1_mid[r] <= med3(win[r][0], win[r][1], win[r][2]);
        s1_min[r] <= min3(win[r][0], win[r][1], win[r][2]);
      end
      s1_center <= win[1][1];
      s1_sync   <= s0_sync;
      s1_border <= s0_border;
    end
  end

  // S2: cross-row reduction
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s2_max_of_mins  <= '0;
      s2_mid_of_mids  <= '0;
      s2_min_of_maxes <= '0;
      s2_center       <= '0;
      s2_sync         <= '0;
      s2_border       <= 1'b0;
    end else begin
      s2_max_of_mins  <= max3(s1_min[0], s1_min[1], s1_min[2]);
      s2_mid_of_mids  <= med3(s1_mid[0], s1_mid[1], s1_mid[2]);
      s2_min_of_maxes <= min3(s1_max[0], s1_max[1], s1_max[2]);
      s2_center       <= s1_center;
      s2_sync         <= s1_sync;
      s2_border       <= s1_border;
    end
  end

  // S3: final median; pixel output holds between strobes
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_y       <= '0;
    end else begin
      post_frame_vsync <= s2_sync[2];
      post_frame_href  <= s2_sync[1];
      post_frame_clken <= s2_sync[0];
      if (s2_sync[0]) begin
        post_img_y <= s2_border ? s2_center
                                : med3(s2_max_of_mins, s2_mid_of_mids, s2_min_of_maxes);
      end
    end
  end

endmodule

// File: tb/tb_median_window_3x3.sv
// Randomized bench for median_window_3x3: frames are driven through a line-RAM-like
// row view, a plain 9-value sort model predicts each output into a scoreboard queue.
module tb_median_window_3x3;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       vsync, href, clken;
  logic [7:0] top, mid, bot;
  logic       post_vsync, post_href, post_clken;
  logic [7:0] post_y;

  always #5 clock = ~clock;

  median_window_3x3 #(.DATA_W(8), .COL_W(11), .LINE_W(11)) dut (
    .clock            (clock),
    .rst_n            (rst_n),
    .per_frame_vsync  (vsync),
    .per_frame_href   (href),
    .per_frame_clken  (clken),
    .row_top          (top),
    .row_mid          (mid),
    .row_bot          (bot),
    .post_frame_vsync (post_vsync),
    .post_frame_href  (post_href),
    .post_frame_clken (post_clken),
    .post_img_y       (post_y)
  );

  int checks = 0;
  int errors = 0;
  int out_count = 0;

  logic [7:0] exp_q[$];
  logic [2:0] in_hist[$];
  logic [7:0] last_y = 8'd0;

  logic [7:0] img [16][16];
  logic [7:0] h_top [3];
  logic [7:0] h_mid [3];
  logic [7:0] h_bot [3];
  int m_line, m_col;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] median9(input logic [7:0] v [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = v;
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
      end
    end
    return s[4];
  endfunction

  function automatic logic [7:0] pix(input int l, input int c);
    if (l < 0) return 8'd0;
    return img[l][c];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      h_top[i] = 8'd0; h_mid[i] = 8'd0; h_bot[i] = 8'd0;
    end
    m_line = 0;
    m_col  = 0;
  endtask

  // Window = the last three accepted column triples; edges pass the centre pixel.
  task automatic model_accept(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    logic [7:0] v [9];
    for (int i = 2; i > 0; i--) begin
      h_top[i] = h_top[i-1]; h_mid[i] = h_mid[i-1]; h_bot[i] = h_bot[i-1];
    end
    h_top[0] = t; h_mid[0] = m; h_bot[0] = b;
    for (int i = 0; i < 3; i++) begin
      v[i] = h_top[i]; v[3+i] = h_mid[i]; v[6+i] = h_bot[i];
    end
    if (m_col < 2 || m_line < 2) exp_q.push_back(h_mid[1]);
    else exp_q.push_back(median9(v));
    m_col++;
  endtask

  task automatic tick(input logic vs, input logic hs, input logic ce,
                      input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    @(negedge clock);
    vsync = vs; href = hs; clken = ce; top = t; mid = m; bot = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic do_reset_midline();
    @(negedge clock);
    rst_n = 1'b0; href = 1'b0; clken = 1'b0; vsync = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_vsync", int'(post_vsync), 0);
    check("midreset_href",  int'(post_href),  0);
    check("midreset_clken", int'(post_clken), 0);
    check("midreset_y",     int'(post_y),     0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    model_clear();
  endtask

  // mode 0: dense clken, 1: random gaps, 2: repeating 1,0,0,1,1,0,1 pattern
  task automatic drive_frame(input int w, input int h, input int mode,
                             input int rst_line, input int rst_col);
    logic [6:0] pat;
    int pi;
    int col;
    bit ce;
    bit aborted;
    pat = 7'b1011001;
    tick(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    m_line = 0;
    tick(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(2);
    for (int l = 0; l < h; l++) begin
      col = 0;
      pi = 0;
      m_col = 0;
      aborted = 1'b0;
      while (col < w && !aborted) begin
        case (mode)
          0:       ce = 1'b1;
          1:       ce = ($urandom_range(0, 3) != 0);
          default: begin ce = pat[pi]; pi = (pi + 1) % 7; end
        endcase
        if (ce && l == rst_line && col == rst_col) begin
          do_reset_midline();
          aborted = 1'b1;
        end else if (ce) begin
          tick(1'b0, 1'b1, 1'b1, pix(l-2, col), pix(l-1, col), pix(l, col));
          model_accept(pix(l-2, col), pix(l-1, col), pix(l, col));
          col++;
        end else begin
          tick(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        end
      end
      idle(3);
      if (!aborted) m_line++;
      m_col = 0;
    end
    idle(2);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int l = 0; l < 16; l++)
      for (int c = 0; c < 16; c++) img[l][c] = v;
  endtask

  task automatic fill_random();
    for (int l = 0; l < 16; l++)
      for (int c = 0; c < 16; c++) img[l][c] = 8'($urandom);
  endtask

  // Sync outputs compare against the inputs seen four edges earlier; pixels against the queue.
  always @(posedge clock) begin
    logic [2:0] cur;
    cur = {vsync, href, clken};
    #2;
    if (!rst_n) begin
      in_hist = '{3'b000, 3'b000, 3'b000};
      last_y = 8'd0;
    end else begin
      in_hist.push_back(cur);
      if (in_hist.size() >= 4) begin
        check("sync_delay", int'({post_vsync, post_href, post_clken}), int'(in_hist[0]));
        void'(in_hist.pop_front());
      end
      if (post_clken) begin
        out_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          last_y = exp_q.pop_front();
          check("pixel", int'(post_y), int'(last_y));
        end
      end else begin
        check("pixel_hold", int'(post_y), int'(last_y));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    vsync = 1'b0; href = 1'b0; clken = 1'b0;
    top = 8'd0; mid = 8'd0; bot = 8'd0;
    model_clear();
    repeat (3) @(negedge clock);
    check("reset_vsync", int'(post_vsync), 0);
    check("reset_href",  int'(post_href),  0);
    check("reset_clken", int'(post_clken), 0);
    check("reset_y",     int'(post_y),     0);
    rst_n = 1'b1;
    idle(2);

    fill(8'h5A);
    out_count = 0;
    drive_frame(8, 6, 0, -1, -1);
    idle(6);
    check("uniform_count", out_count, 48);

    fill(8'h00);
    img[3][4] = 8'hFF;
    drive_frame(8, 6, 0, -1, -1);

    fill(8'h00);
    img[2][2] = 8'd9; img[2][3] = 8'd8; img[2][4] = 8'd7;
    img[3][2] = 8'd6; img[3][3] = 8'd5; img[3][4] = 8'd4;
    img[4][2] = 8'd3; img[4][3] = 8'd2; img[4][4] = 8'd1;
    drive_frame(8, 6, 0, -1, -1);

    for (int l = 0; l < 16; l++)
      for (int c = 0; c < 16; c++) img[l][c] = 8'(c + 16 * l);
    drive_frame(8, 6, 0, -1, -1);

    fill_random();
    drive_frame(9, 6, 2, -1, -1);

    fill_random();
    drive_frame(8, 6, 0, 3, 5);
    drive_frame(8, 6, 0, -1, -1);

    for (int k = 0; k < 4; k++) begin
      fill_random();
      drive_frame($urandom_range(4, 12), $urandom_range(3, 8), 1, -1, -1);
    end

    idle(10);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/median_window_3x3.md
Name: median_window_3x3

Overview:
- Consumer end of the 8-bit two-line shift RAM in the median filter path.
- Takes the three row-aligned pixel streams: the row-before-previous tap, the previous-row tap, and the current pixel.
- Builds a 3x3 window, computes its median through a pipelined sorting network, and re-emits pixel data with vsync/href/clken delayed to match.
- Sits between the line shift RAM and the downstream scaler/display path.

Parameters:
DATA_W, 8, pixel width in bits
COL_W, 11, column counter width (max 2047 pixels per line)
LINE_W, 11, line counter width (max 2047 lines per frame)

Ports:
clock  input  1  system pixel clock, rising edge
rst_n  input  1  asynchronous active-low reset
per_frame_vsync  input  1  frame sync, active high
per_frame_href  input  1  line valid, active high
per_frame_clken  input  1  pixel strobe, qualifies the row inputs
row_top  input  DATA_W  pixel from the row before the previous row (line RAM taps1x)
row_mid  input  DATA_W  pixel from the previous row (line RAM taps0x)
row_bot  input  DATA_W  current-row pixel, time-aligned with row_mid and row_top
post_frame_vsync  output  1  vsync delayed 4 clocks
post_frame_href  output  1  href delayed 4 clocks
post_frame_clken  output  1  clken delayed 4 clocks
post_img_y  output  DATA_W  filtered pixel

Behaviour:
- Reset: all window registers, counters, pipeline registers and outputs clear to 0 asynchronously on rst_n low. Deassertion acts on the next clock edge.
- Window stage (S0):
  - Three 3-deep column shift registers per row.
  - On clken: col2<=col1, col1<=col0, col0<=input. Without clken the window holds.
  - S0 also registers valid=clken and a border flag.
- Column counter:
  - Increments on clken while href is high.
  - Clears to 0 whenever href is low.
  - Saturates at 2^COL_W-1.
- Line counter:
  - Increments on each href falling edge (href registered last cycle = 1, now = 0).
  - Clears on the vsync rising edge.
  - Saturates at 2^LINE_W-1.
- Border flag: set when, at the clken being accepted, col_cnt<2 or line_cnt<2, with counter values taken before increment.
- Center pixel: row_mid col1 after the shift, carried alongside the pipeline.
- S1: each window row sorted into max/mid/min (3-comparator network). Unsigned compare. Ties resolve by position, with the lowest-index value taken first as max.
- S2: max_of_mins, mid_of_mids, min_of_maxes.
- S3: median of those three values.
  - post_img_y = median when the border flag is clear, otherwise the center pixel.
  - No arithmetic widening; all values stay DATA_W.
- Latency: fixed 4 clocks from input to output for every sync signal and for data.
  - post_frame_clken is high exactly 4 clocks after each input clken.
  - post_img_y is only meaningful when post_frame_clken is high; it holds its last value otherwise.
- Pipeline flow: S1–S3 advance every clock regardless of clken. Gaps in clken propagate unchanged as gaps in post_frame_clken.
- Mid-line reset: all state clears. The first line after release is treated as line 0 until the next vsync edge, because the line counter is 0 and the border rule applies.
- Simultaneous vsync rise and href fall: the vsync clear takes priority, so line_cnt ends at 0.

Test Plan:
- Uniform frame, 8x6, all pixels 0x5A -> every post_frame_clken cycle outputs 0x5A; output count is 48; each sync output equals its input delayed by exactly 4 clocks.
- Impulse: zero frame with a single 0xFF at line 3, column 4 -> output 0x00 at every position, no 0xFF ever emitted.
- Ordered window: rows {9,8,7},{6,5,4},{3,2,1} fed at line≥2, column≥2 -> post_img_y = 5 four clocks after the third column's clken.
- Border: ramp frame with pixel = column index + 16×line -> output equals the center pixel for columns 0–1 and lines 0–1, and the median elsewhere.
- clken gaps: clken pattern 1,0,0,1,1,0,1 during href -> post_frame_clken reproduces the same pattern shifted 4 clocks; window contents match the gap-free reference results.
- Reset mid-line: assert rst_n low during column 5 of line 3 -> all outputs 0 immediately; after release, the first two columns use border passthrough and the line counter restarts at 0.
